// File: rtl/sum_accumulator.sv
// Burst accumulator: sums len_i upstream adder results into a saturating
// acc_bits accumulator and presents the total with a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start_i; acc_o/ovf_o hold the previous result
// ACCUM | accepting sums until the remaining count is exhausted
// DONE  | acc_o valid, waiting for acc_ready_i
module sum_accumulator #(
    parameter int nb_bits  = 32,
    parameter int acc_bits = 40,
    parameter int cnt_bits = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [cnt_bits-1:0] len_i,
    input  logic [nb_bits:0]    sum_i,
    input  logic                sum_valid_i,
    output logic                sum_ready_o,
    output logic [acc_bits-1:0] acc_o,
    output logic                acc_valid_o,
    input  logic                acc_ready_i,
    output logic                busy_o,
    output logic                ovf_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int ext_bits = acc_bits - (nb_bits + 1);

    state_t              state_q, state_d;
    logic [acc_bits-1:0] acc_q, acc_d;
    logic                ovf_q, ovf_d;
    logic [cnt_bits-1:0] rem_q, rem_d;
    logic [acc_bits:0]   add_res;

    // One extra bit captures the carry out of the accumulator for saturation.
    assign add_res = {1'b0, acc_q} + {{(ext_bits + 1){1'b0}}, sum_i};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (len_i != '0) begin
                        rem_d   = len_i;
                        state_d = ACCUM;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ACCUM: begin
                if (sum_valid_i) begin
                    if (add_res[acc_bits]) begin
                        acc_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = add_res[acc_bits-1:0];
                    end
                    rem_d = rem_q - cnt_bits'(1);
                    if (rem_q == cnt_bits'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (acc_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            rem_q   <= rem_d;
        end
    end

    assign sum_ready_o = (state_q == ACCUM);
    assign acc_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign acc_o       = acc_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator: a reference model pushes expected
// burst totals to a scoreboard that is popped when acc_valid_o is seen.
module tb_sum_accumulator;

    localparam int NB  = 32;
    localparam int ACC = 34;
    localparam int CNT = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [CNT-1:0] len;
    logic [NB:0]    sum;
    logic           sum_valid;
    logic           sum_ready;
    logic [ACC-1:0] acc;
    logic           acc_valid;
    logic           acc_ready;
    logic           busy;
    logic           ovf;

    int checks   = 0;
    int failures = 0;

    logic [ACC-1:0] m_acc;
    logic           m_ovf;
    logic [ACC-1:0] exp_acc_q[$];
    logic           exp_ovf_q[$];

    sum_accumulator #(.nb_bits(NB), .acc_bits(ACC), .cnt_bits(CNT)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .len_i      (len),
        .sum_i      (sum),
        .sum_valid_i(sum_valid),
        .sum_ready_o(sum_ready),
        .acc_o      (acc),
        .acc_valid_o(acc_valid),
        .acc_ready_i(acc_ready),
        .busy_o     (busy),
        .ovf_o      (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic begin_burst(input logic [CNT-1:0] l);
        @(negedge clk);
        start = 1'b1;
        len   = l;
        m_acc = '0;
        m_ovf = 1'b0;
        @(negedge clk);
        start = 1'b0;
        len   = '0;
    endtask

    // Drive one sum for one cycle and advance the reference model.
    task automatic send_sum(input logic [NB:0] s);
        logic [ACC:0] t;
        sum       = s;
        sum_valid = 1'b1;
        t = {1'b0, m_acc} + {{(ACC - NB){1'b0}}, s};
        if (t[ACC]) begin
            m_acc = '1;
            m_ovf = 1'b1;
        end else begin
            m_acc = t[ACC-1:0];
        end
        @(negedge clk);
        sum_valid = 1'b0;
        sum       = '0;
    endtask

    task automatic push_expected();
        exp_acc_q.push_back(m_acc);
        exp_ovf_q.push_back(m_ovf);
    endtask

    task automatic handshake();
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({acc_valid, sum_ready, busy, ovf} !== 4'b0000 || acc !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got acc=%h v=%b rdy=%b busy=%b ovf=%b want all 0",
                     acc, acc_valid, sum_ready, busy, ovf);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [ACC-1:0] e_acc;
        logic           e_ovf;
        begin_burst(8'd3);
        checks++;
        if (sum_ready !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_accum_state: got rdy=%b busy=%b want 1 1", sum_ready, busy);
        end
        send_sum(33'h1_0000_0000);
        send_sum(33'h0_0000_0005);
        checks++;
        if (acc_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_early_valid: got %b want 0", acc_valid);
        end
        send_sum(33'h0_FFFF_FFFF);
        push_expected();
        checks++;
        if (acc_valid !== 1'b1 || sum_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_latency: got v=%b rdy=%b want 1 0", acc_valid, sum_ready);
        end
        checks++;
        if (exp_acc_q.size() == 0) begin
            failures++;
            $display("FAIL basic_scoreboard: got empty queue want 1 entry");
        end else begin
            e_acc = exp_acc_q.pop_front();
            e_ovf = exp_ovf_q.pop_front();
            if (acc !== e_acc || ovf !== e_ovf || acc !== 34'h2_0000_0004) begin
                failures++;
                $display("FAIL basic_result: got acc=%h ovf=%b want acc=%h ovf=%b", acc, ovf, e_acc, e_ovf);
            end
        end
        handshake();
        checks++;
        if (acc_valid !== 1'b0 || busy !== 1'b0 || acc !== 34'h2_0000_0004) begin
            failures++;
            $display("FAIL basic_idle_hold: got v=%b busy=%b acc=%h want 0 0 200000004",
                     acc_valid, busy, acc);
        end
    endtask

    task automatic test_bubbles();
        logic [ACC-1:0] e_acc;
        begin_burst(8'd2);
        send_sum(33'd7);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (acc !== 34'd7 || sum_ready !== 1'b1 || acc_valid !== 1'b0) begin
                failures++;
                $display("FAIL bubble_hold[%0d]: got acc=%h rdy=%b v=%b want 7 1 0",
                         i, acc, sum_ready, acc_valid);
            end
            @(negedge clk);
        end
        send_sum(33'd9);
        push_expected();
        checks++;
        if (exp_acc_q.size() == 0) begin
            failures++;
            $display("FAIL bubble_scoreboard: got empty queue want 1 entry");
        end else begin
            e_acc = exp_acc_q.pop_front();
            void'(exp_ovf_q.pop_front());
            if (acc_valid !== 1'b1 || acc !== e_acc || acc !== 34'd16) begin
                failures++;
                $display("FAIL bubble_result: got v=%b acc=%h want 1 %h", acc_valid, acc, e_acc);
            end
        end
        handshake();
    endtask

    task automatic test_backpressure();
        logic [ACC-1:0] e_acc;
        begin_burst(8'd1);
        send_sum(33'h123);
        push_expected();
        e_acc = exp_acc_q.pop_front();
        void'(exp_ovf_q.pop_front());
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len   = 8'd5;
            checks++;
            if (acc_valid !== 1'b1 || acc !== e_acc || busy !== 1'b1 || sum_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_hold[%0d]: got v=%b acc=%h busy=%b rdy=%b want 1 %h 1 0",
                         i, acc_valid, acc, busy, sum_ready, e_acc);
            end
            @(negedge clk);
        end
        start = 1'b0;
        len   = '0;
        handshake();
        checks++;
        if (acc_valid !== 1'b0 || busy !== 1'b0 || acc !== e_acc) begin
            failures++;
            $display("FAIL backpressure_release: got v=%b busy=%b acc=%h want 0 0 %h",
                     acc_valid, busy, acc, e_acc);
        end
    endtask

    task automatic test_saturation();
        logic [ACC-1:0] e_acc;
        logic           e_ovf;
        begin_burst(8'd3);
        repeat (3) send_sum(33'h1_FFFF_FFFF);
        push_expected();
        e_acc = exp_acc_q.pop_front();
        e_ovf = exp_ovf_q.pop_front();
        checks++;
        if (acc_valid !== 1'b1 || acc !== e_acc || ovf !== e_ovf || acc !== 34'h3_FFFF_FFFF || ovf !== 1'b1) begin
            failures++;
            $display("FAIL saturate_result: got v=%b acc=%h ovf=%b want 1 %h %b",
                     acc_valid, acc, ovf, e_acc, e_ovf);
        end
        handshake();
        checks++;
        if (ovf !== 1'b1 || acc !== 34'h3_FFFF_FFFF) begin
            failures++;
            $display("FAIL saturate_idle_hold: got acc=%h ovf=%b want 3ffffffff 1", acc, ovf);
        end
        begin_burst(8'd1);
        send_sum(33'd1);
        push_expected();
        e_acc = exp_acc_q.pop_front();
        e_ovf = exp_ovf_q.pop_front();
        checks++;
        if (acc_valid !== 1'b1 || acc !== e_acc || ovf !== e_ovf || ovf !== 1'b0) begin
            failures++;
            $display("FAIL saturate_next_burst: got v=%b acc=%h ovf=%b want 1 %h %b",
                     acc_valid, acc, ovf, e_acc, e_ovf);
        end
        handshake();
    endtask

    task automatic test_zero_len();
        logic seen_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        len   = '0;
        m_acc = '0;
        m_ovf = 1'b0;
        push_expected();
        @(negedge clk);
        start = 1'b0;
        seen_ready = sum_ready;
        checks++;
        if (acc_valid !== 1'b1 || acc !== exp_acc_q.pop_front() || ovf !== exp_ovf_q.pop_front()) begin
            failures++;
            $display("FAIL zero_len_result: got v=%b acc=%h ovf=%b want 1 0 0", acc_valid, acc, ovf);
        end
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
        seen_ready = seen_ready | sum_ready;
        checks++;
        if (seen_ready !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_ready: got seen_rdy=%b busy=%b want 0 0", seen_ready, busy);
        end
    endtask

    task automatic test_reset_mid();
        begin_burst(8'd4);
        send_sum(33'd100);
        send_sum(33'd200);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({acc_valid, sum_ready, busy, ovf} !== 4'b0000 || acc !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got acc=%h v=%b rdy=%b busy=%b ovf=%b want all 0",
                     acc, acc_valid, sum_ready, busy, ovf);
        end
        begin_burst(8'd1);
        send_sum(33'd5);
        push_expected();
        checks++;
        if (acc_valid !== 1'b1 || acc !== exp_acc_q.pop_front() || acc !== 34'd5) begin
            failures++;
            $display("FAIL reset_mid_new_burst: got v=%b acc=%h want 1 5", acc_valid, acc);
        end
        void'(exp_ovf_q.pop_front());
        handshake();
    endtask

    task automatic test_back_to_back();
        begin_burst(8'd255);
        for (int i = 0; i < 254; i++) send_sum(33'd1);
        checks++;
        if (acc_valid !== 1'b0 || sum_ready !== 1'b1 || acc !== 34'd254) begin
            failures++;
            $display("FAIL max_len_pre_final: got v=%b rdy=%b acc=%h want 0 1 fe", acc_valid, sum_ready, acc);
        end
        send_sum(33'd1);
        push_expected();
        checks++;
        if (acc_valid !== 1'b1 || acc !== exp_acc_q.pop_front() || acc !== 34'd255) begin
            failures++;
            $display("FAIL max_len_result: got v=%b acc=%h want 1 ff", acc_valid, acc);
        end
        void'(exp_ovf_q.pop_front());
        handshake();
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        sum       = '0;
        sum_valid = 1'b0;
        acc_ready = 1'b0;
        m_acc     = '0;
        m_ovf     = 1'b0;
        test_reset();
        test_basic();
        test_bubbles();
        test_backpressure();
        test_saturation();
        test_zero_len();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (exp_acc_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_acc_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
